debug_run_control: RTL and testbench
====================================

// Module: debug_run_control
// PURPOSE
//  Run-control FSM of the MIPS debug unit, directly upstream of the cycle counter.
//  Decodes command bytes from the UART RX path and drives en_pipeline_o, which
//  freezes/advances the pipeline and is wired to the cycle counter's en_count_i.
//  Supports continuous run to HALT, single step, a watchdog limit on continuous
//  runs, and a report handshake to the UART TX sender after each run or step.
// PARAMETERS
//  NB_CMD    8    command byte width
//  NB_WDOG   16   watchdog counter width; RUN times out at 2**NB_WDOG-1 cycles
//  CMD_CONT  8'h63 ('c')  start continuous run
//  CMD_STEP  8'h73 ('s')  advance pipeline exactly one cycle
//  CMD_CLEAR 8'h78 ('x')  leave DONE, pulse clear_o
// PORTS
//  clock_i        in   1       system clock
//  reset_i        in   1       asynchronous reset, active-low
//  cmd_valid_i    in   1       command byte available
//  cmd_data_i     in   NB_CMD  command byte
//  cmd_ready_o    out  1       command accepted this cycle (valid & ready = consume)
//  halt_i         in   1       HALT instruction has reached WB
//  en_pipeline_o  out  1       pipeline/counter advance enable
//  clear_o        out  1       1-cycle pulse: sync-clear cycle counter and PC
//  report_req_o   out  1       request TX sender to dump counter/regs
//  report_ack_i   in   1       TX sender finished dump
//  halted_o       out  1       program has reached HALT (sticky until CLEAR)
//  timeout_o      out  1       last RUN ended by watchdog (sticky until CLEAR)
//  state_o        out  3       current state encoding, for debug
// BEHAVIOUR
//  - Reset (reset_i=0, async): state=IDLE; all outputs 0; watchdog=0.
//  - All outputs are registered or decoded from the state register only (Moore);
//    no combinational path from any input to any output except cmd_ready_o.
//  - States: IDLE=0, RUN=1, STEP=2, REPORT=3, DONE=4; others -> IDLE.
//  - cmd_ready_o=1 only in IDLE and DONE; bytes arriving elsewhere are stalled.
//  - IDLE: CONT -> RUN (watchdog cleared); STEP -> STEP; CLEAR -> pulse clear_o,
//    stay IDLE; unknown byte consumed and dropped.
//  - RUN: en_pipeline_o=1; watchdog +1 per cycle. At edge with halt_i=1 ->
//    REPORT, set halted_o. Else at watchdog==2**NB_WDOG-1 -> REPORT, set
//    timeout_o. halt_i wins if both occur in the same cycle (timeout_o stays 0).
//  - STEP: en_pipeline_o=1 for exactly one cycle, then REPORT; halt_i=1 on that
//    edge sets halted_o.
//  - REPORT: en_pipeline_o=0; report_req_o=1 until report_ack_i sampled 1, then
//    DONE if halted_o|timeout_o else IDLE. report_ack_i outside REPORT ignored.
//  - DONE: pipeline frozen; CONT/STEP consumed and dropped; CLEAR -> pulse
//    clear_o, clear halted_o/timeout_o, -> IDLE.
//  - Cycles counted downstream equal cycles with en_pipeline_o=1, including the
//    cycle in which halt_i is first seen.
//  - Watchdog saturates; never wraps. Mid-operation reset aborts to IDLE instantly.
// STRUCTURE
//  - Shared package/header: command byte constants, state encodings, NB_CMD.
//  - One sub-module: debug_watchdog (clear, enable, saturating count, expired flag).
//  - FSM, sticky flags and output decode in this module.
// TESTING
//  - Reset mid-RUN -> next cycle state_o=0, en_pipeline_o=0, halted_o=0.
//  - 'c', halt_i=1 after 10 enabled cycles -> en_pipeline_o high exactly 10 cycles,
//    report_req_o=1, after ack: state=DONE, halted_o=1.
//  - 's' in IDLE -> en_pipeline_o high exactly 1 cycle, report_req_o, after
//    ack state=IDLE; 3 steps -> 3 enabled cycles total.
//  - NB_WDOG=4, 'c', halt_i=0 -> 15 enabled cycles, timeout_o=1, DONE;
//    halt_i and expiry in same cycle -> halted_o=1, timeout_o=0.
//  - In DONE send 's' then 'x' -> 's' consumed, no enable; 'x' -> clear_o
//    1-cycle pulse, flags 0, state=IDLE.
//  - cmd_valid_i held during RUN -> cmd_ready_o=0 until DONE/IDLE, byte kept.

Source files
------------

// File: rtl/debug_run_control_pkg.sv
// Shared definitions for the debug run-control block: command bytes and
// the state encoding that is exported on state_o.
package debug_run_control_pkg;

   localparam int NB_CMD = 8;

   localparam logic [NB_CMD-1:0] CMD_CONT  = 8'h63;  // 'c'
   localparam logic [NB_CMD-1:0] CMD_STEP  = 8'h73;  // 's'
   localparam logic [NB_CMD-1:0] CMD_CLEAR = 8'h78;  // 'x'

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_STEP   = 3'd2,
      ST_REPORT = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/debug_watchdog.sv
// Saturating cycle watchdog for continuous runs. expired_o flags the enabled
// cycle that brings the count to its maximum, so a run lasts 2**NB_WDOG-1 cycles.
module debug_watchdog #(
   parameter int NB_WDOG = 16
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [NB_WDOG-1:0] WDOG_MAX  = '1;
   localparam logic [NB_WDOG-1:0] WDOG_LAST = WDOG_MAX - NB_WDOG'(1);

   logic [NB_WDOG-1:0] count_q;
   logic [NB_WDOG-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != WDOG_MAX)) begin
         count_d = count_q + NB_WDOG'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = en_i && (count_q >= WDOG_LAST);

endmodule

// File: rtl/debug_run_control.sv
// Run-control FSM of the debug unit: decodes UART command bytes into pipeline
// enable, single step, watchdog-limited run, and the report handshake.
module debug_run_control
   import debug_run_control_pkg::*;
#(
   parameter int NB_WDOG = 16
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              cmd_valid_i,
   input  logic [NB_CMD-1:0] cmd_data_i,
   output logic              cmd_ready_o,
   input  logic              halt_i,
   output logic              en_pipeline_o,
   output logic              clear_o,
   output logic              report_req_o,
   input  logic              report_ack_i,
   output logic              halted_o,
   output logic              timeout_o,
   output logic [2:0]        state_o
);

   state_e state_q, state_d;
   logic   halted_q, halted_d;
   logic   timeout_q, timeout_d;
   logic   clear_q, clear_d;
   logic   wdog_clear;
   logic   wdog_expired;
   logic   cmd_fire;

   assign cmd_ready_o = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign cmd_fire    = cmd_valid_i && cmd_ready_o;

   debug_watchdog #(.NB_WDOG(NB_WDOG)) u_watchdog (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .clear_i   (wdog_clear),
      .en_i      (state_q == ST_RUN),
      .expired_o (wdog_expired)
   );

   // NOTE: every variable driven here gets a default first; a path that left one
   // unassigned would infer a latch.
   always_comb begin
      state_d    = state_q;
      halted_d   = halted_q;
      timeout_d  = timeout_q;
      clear_d    = 1'b0;
      wdog_clear = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               case (cmd_data_i)
                  CMD_CONT: begin
                     state_d    = ST_RUN;
                     wdog_clear = 1'b1;
                  end
                  CMD_STEP:  state_d = ST_STEP;
                  CMD_CLEAR: clear_d = 1'b1;
                  default:   ;
               endcase
            end
         end
         ST_RUN: begin
            // HALT takes priority over a watchdog expiry in the same cycle.
            if (halt_i) begin
               state_d  = ST_REPORT;
               halted_d = 1'b1;
            end else if (wdog_expired) begin
               state_d   = ST_REPORT;
               timeout_d = 1'b1;
            end
         end
         ST_STEP: begin
            state_d = ST_REPORT;
            if (halt_i) begin
               halted_d = 1'b1;
            end
         end
         ST_REPORT: begin
            if (report_ack_i) begin
               state_d = (halted_q || timeout_q) ? ST_DONE : ST_IDLE;
            end
         end
         ST_DONE: begin
            if (cmd_fire && (cmd_data_i == CMD_CLEAR)) begin
               state_d   = ST_IDLE;
               clear_d   = 1'b1;
               halted_d  = 1'b0;
               timeout_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= ST_IDLE;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
         clear_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         halted_q  <= halted_d;
         timeout_q <= timeout_d;
         clear_q   <= clear_d;
      end
   end

   assign en_pipeline_o = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign report_req_o  = (state_q == ST_REPORT);
   assign clear_o       = clear_q;
   assign halted_o      = halted_q;
   assign timeout_o     = timeout_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_debug_run_control.sv
// Scoreboard bench for debug_run_control: stimulus queues expected report and
// clear events, a monitor acting as the TX sender pops and checks them.
module tb_debug_run_control;
   import debug_run_control_pkg::*;

   localparam int NB_WDOG = 4;

   logic              clock_i = 1'b0;
   logic              reset_i = 1'b0;
   logic              cmd_valid_i = 1'b0;
   logic [NB_CMD-1:0] cmd_data_i = '0;
   logic              halt_i = 1'b0;
   logic              report_ack_i = 1'b0;
   logic              cmd_ready_o;
   logic              en_pipeline_o;
   logic              clear_o;
   logic              report_req_o;
   logic              halted_o;
   logic              timeout_o;
   logic [2:0]        state_o;

   debug_run_control #(.NB_WDOG(NB_WDOG)) dut (
      .clock_i       (clock_i),
      .reset_i       (reset_i),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_data_i    (cmd_data_i),
      .cmd_ready_o   (cmd_ready_o),
      .halt_i        (halt_i),
      .en_pipeline_o (en_pipeline_o),
      .clear_o       (clear_o),
      .report_req_o  (report_req_o),
      .report_ack_i  (report_ack_i),
      .halted_o      (halted_o),
      .timeout_o     (timeout_o),
      .state_o       (state_o)
   );

   always #5 clock_i = ~clock_i;

   typedef enum int {EV_REPORT = 0, EV_CLEAR = 1} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       en_cycles;
      logic     halted;
      logic     timeout;
      state_e   next_state;
   } exp_t;

   exp_t sb_q[$];
   int   total_cnt = 0;
   int   pass_cnt  = 0;
   int   en_cnt    = 0;
   int   en_base   = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
   endtask

   // Enabled cycles seen by the downstream cycle counter.
   always @(negedge clock_i) begin
      if (en_pipeline_o === 1'b1) en_cnt <= en_cnt + 1;
   end

   // Monitor: plays the TX sender and checks each report / clear event.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock_i);
         if (report_req_o === 1'b1) begin
            check("sb_has_report", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("ev_kind_report", 32'(e.kind), 32'(EV_REPORT));
               check("en_cycles", 32'(en_cnt - en_base), 32'(e.en_cycles));
               check("halted_at_report", 32'(halted_o), 32'(e.halted));
               check("timeout_at_report", 32'(timeout_o), 32'(e.timeout));
               check("en_off_in_report", 32'(en_pipeline_o), 0);
               @(negedge clock_i);
               check("req_held", 32'(report_req_o), 1);
               report_ack_i = 1'b1;
               @(posedge clock_i);
               #1 report_ack_i = 1'b0;
               check("state_after_ack", 32'(state_o), 32'(e.next_state));
               check("req_dropped", 32'(report_req_o), 0);
               en_base = en_cnt;
            end
         end else if (clear_o === 1'b1) begin
            check("sb_has_clear", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("ev_kind_clear", 32'(e.kind), 32'(EV_CLEAR));
               check("clear_halted", 32'(halted_o), 0);
               check("clear_timeout", 32'(timeout_o), 0);
               check("clear_state", 32'(state_o), 32'(ST_IDLE));
               @(negedge clock_i);
               check("clear_pulse_width", 32'(clear_o), 0);
            end
         end
      end
   end

   task automatic send_cmd(input logic [NB_CMD-1:0] b);
      int i;
      @(negedge clock_i);
      cmd_valid_i = 1'b1;
      cmd_data_i  = b;
      i = 0;
      while (cmd_ready_o !== 1'b1 && i < 100) begin
         @(negedge clock_i);
         i++;
      end
      check("cmd_accept", 32'(cmd_ready_o), 1);
      @(posedge clock_i);
      #1 cmd_valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while (sb_q.size() != 0 && i < 200) begin
         @(negedge clock_i);
         i++;
      end
      repeat (3) @(negedge clock_i);
      check("drain", 32'(sb_q.size()), 0);
   endtask

   task automatic push_report(input int n, input logic h, input logic t, input state_e s);
      exp_t e;
      e.kind = EV_REPORT; e.en_cycles = n; e.halted = h; e.timeout = t; e.next_state = s;
      sb_q.push_back(e);
   endtask

   task automatic push_clear();
      exp_t e;
      e.kind = EV_CLEAR; e.en_cycles = 0; e.halted = 1'b0; e.timeout = 1'b0; e.next_state = ST_IDLE;
      sb_q.push_back(e);
   endtask

   initial begin : stimulus
      int snap;
      repeat (2) @(negedge clock_i);
      check("rst_state", 32'(state_o), 32'(ST_IDLE));
      check("rst_en", 32'(en_pipeline_o), 0);
      check("rst_clear", 32'(clear_o), 0);
      check("rst_req", 32'(report_req_o), 0);
      check("rst_halted", 32'(halted_o), 0);
      check("rst_timeout", 32'(timeout_o), 0);
      reset_i = 1'b1;

      // CLEAR in IDLE, then an unknown byte is swallowed
      push_clear();
      send_cmd(CMD_CLEAR);
      wait_drain();
      send_cmd(8'h41);
      repeat (3) @(negedge clock_i);
      check("unknown_state", 32'(state_o), 32'(ST_IDLE));
      check("unknown_no_en", 32'(en_cnt), 0);

      // three single steps
      for (int k = 0; k < 3; k++) begin
         push_report(1, 1'b0, 1'b0, ST_IDLE);
         send_cmd(CMD_STEP);
         wait_drain();
      end
      check("step_total_en", 32'(en_cnt), 3);

      // continuous run, HALT during the 10th enabled cycle
      push_report(10, 1'b1, 1'b0, ST_DONE);
      send_cmd(CMD_CONT);
      repeat (10) @(negedge clock_i);
      halt_i = 1'b1;
      @(posedge clock_i);
      #1 halt_i = 1'b0;
      wait_drain();

      // 's' in DONE is dropped; 'x' clears
      snap = en_cnt;
      send_cmd(CMD_STEP);
      repeat (3) @(negedge clock_i);
      check("done_step_state", 32'(state_o), 32'(ST_DONE));
      check("done_step_no_en", 32'(en_cnt), 32'(snap));
      push_clear();
      send_cmd(CMD_CLEAR);
      wait_drain();

      // watchdog expiry: 15 cycles, no HALT
      push_report(15, 1'b0, 1'b1, ST_DONE);
      send_cmd(CMD_CONT);
      wait_drain();
      push_clear();
      send_cmd(CMD_CLEAR);
      wait_drain();

      // HALT in the expiry cycle wins
      push_report(15, 1'b1, 1'b0, ST_DONE);
      send_cmd(CMD_CONT);
      repeat (15) @(negedge clock_i);
      halt_i = 1'b1;
      @(posedge clock_i);
      #1 halt_i = 1'b0;
      wait_drain();
      push_clear();
      send_cmd(CMD_CLEAR);
      wait_drain();

      // byte held during RUN is stalled, then taken in DONE
      push_report(5, 1'b1, 1'b0, ST_DONE);
      push_clear();
      send_cmd(CMD_CONT);
      cmd_valid_i = 1'b1;
      cmd_data_i  = CMD_CLEAR;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock_i);
         check("stall_ready", 32'(cmd_ready_o), 0);
      end
      @(negedge clock_i);
      halt_i = 1'b1;
      @(posedge clock_i);
      #1 halt_i = 1'b0;
      for (int k = 0; k < 100 && cmd_ready_o !== 1'b1; k++) @(negedge clock_i);
      check("stall_accept", 32'(cmd_ready_o), 1);
      @(posedge clock_i);
      #1 cmd_valid_i = 1'b0;
      wait_drain();
      check("stall_final_state", 32'(state_o), 32'(ST_IDLE));

      // asynchronous reset in the middle of a run
      send_cmd(CMD_CONT);
      repeat (3) @(negedge clock_i);
      check("pre_reset_run", 32'(state_o), 32'(ST_RUN));
      reset_i = 1'b0;
      #1;
      check("midrst_state", 32'(state_o), 32'(ST_IDLE));
      check("midrst_en", 32'(en_pipeline_o), 0);
      check("midrst_halted", 32'(halted_o), 0);
      @(posedge clock_i);
      #1;
      check("midrst_state_hold", 32'(state_o), 32'(ST_IDLE));
      repeat (2) @(negedge clock_i);
      reset_i = 1'b1;
      repeat (2) @(negedge clock_i);
      check("sb_empty_end", 32'(sb_q.size()), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
